instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Upstream feeder for the processor core: buffers 13-bit instruction words pushed by a host
//  in a FIFO and drives the core's instruction register, one word per issue slot. After every
//  ALU op (opcode[12]=1) it inserts bubbles so the 1024-bit ALU writeback settles before the
//  next op. When empty, halted or stalling, it drives a no-write NOP.
// PARAMETERS
//  DEPTH        16   FIFO entries; power of two, >=2
//  BUBBLES      1    NOP cycles after each opcode[12]=1 instruction; 0..7
//  NOP_WORD     13'h0800  idle encoding (opcode 01: no regfile write, no memory write)
// PORTS
//  clock        in   1    single clock; all state on rising edge
//  reset        in   1    asynchronous, active-high; clears all state
//  push_valid   in   1    host offers push_data this cycle
//  push_data    in   13   instruction word {op[12:11], reg[10:9], addr[8:0]}
//  push_ready   out  1    FIFO can accept; transfer = push_valid & push_ready
//  run          in   1    1 = issue allowed; 0 = halt after current cycle (FIFO kept)
//  flush        in   1    sync: drop FIFO contents and pending bubbles
//  instruction_Register out 13  registered word to the core
//  issue_valid  out  1    instruction_Register holds a FIFO word (not a NOP) this cycle
//  fifo_count   out  $clog2(DEPTH)+1  occupancy
//  empty        out  1    fifo_count==0
// BEHAVIOUR
//  Reset: instruction_Register=NOP_WORD, issue_valid=0, fifo_count=0, empty=1,
//   push_ready=1, state=IDLE, bubble counter=0. Reset mid-operation drops all words.
//  FIFO: circular, wr/rd pointers wrap at DEPTH. push_ready = (count<DEPTH) & ~flush.
//   Push and pop in same cycle when full: pop frees slot next cycle only; push_ready stays 0
//   (no same-cycle pass-through). Push+pop when partial: count unchanged.
//  FSM (registered outputs, one-cycle latency from pop to instruction_Register):
//   IDLE : drive NOP. If run & ~empty -> pop, load word, issue_valid=1; go ISSUE.
//   ISSUE: if issued op[12]=1 and BUBBLES>0 -> load counter=BUBBLES, drive NOP, go STALL;
//          else if run & ~empty -> pop next word (back-to-back, 1/cycle); else NOP, go IDLE.
//   STALL: drive NOP, decrement counter; at 1 -> if run & ~empty pop and go ISSUE else IDLE.
//  run=0 observed in any state: no pop that cycle; STALL still counts down (bubbles are
//   never skipped); then IDLE.
//  flush=1: takes priority over pop and push; pointers and count cleared next edge, state->IDLE,
//   output NOP, bubble counter cleared. A word already in instruction_Register is not recalled.
//  Empty FIFO: no pop, no underflow; NOP each cycle. Full FIFO: push ignored (ready=0).
//  Word in instruction_Register is held exactly one cycle; issue_valid pulses with it.
// CONFIGURATION
//  SEQ_PERF_COUNT_EN defined: adds outputs issued_count[31:0] (+1 per issue_valid cycle) and
//   bubble_count[31:0] (+1 per STALL cycle); both reset to 0, saturate at 32'hFFFF_FFFF,
//   cleared by flush. Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 reset mid-run with 5 words queued -> next cycle count=0, instr=13'h0800, issue_valid=0.
//  2 push 0x0012,0x0034 (op 00) with run=1 -> issued on consecutive cycles, no NOP between.
//  3 BUBBLES=2; push 0x1801 (op 11) then 0x0005 -> 0x1801, NOP, NOP, 0x0005.
//  4 fill DEPTH=16 words, run=0 -> push_ready=0, count=16; 17th push dropped; run=1 drains
//    16 words in order, then empty=1 and NOP.
//  5 flush with 7 queued and in STALL -> count=0, state IDLE, NOP next cycle, later push works.
//  6 SEQ_PERF_COUNT_EN: 3 ALU ops, BUBBLES=1 -> issued_count=3, bubble_count=3.

Source files
------------

// File: rtl/instruction_sequencer.sv
// rtl/instruction_sequencer.sv - FIFO-fed instruction issue with post-ALU bubble insertion
// Optional SEQ_PERF_COUNT_EN adds saturating issued_count / bubble_count outputs.
module instruction_sequencer #(
  parameter int          DEPTH    = 16,
  parameter int          BUBBLES  = 1,
  parameter logic [12:0] NOP_WORD = 13'h0800
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [12:0]              push_data,
  output logic                     push_ready,
  input  logic                     run,
  input  logic                     flush,
  output logic [12:0]              instruction_Register,
  output logic                     issue_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     empty
`ifdef SEQ_PERF_COUNT_EN
  ,
  output logic [31:0]              issued_count,
  output logic [31:0]              bubble_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;

  logic [12:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [1:0]    state, state_nxt;
  logic [2:0]    bub_cnt, bub_nxt;
  logic          pop, push_fire, can_pop;

  assign push_ready = (count < FULL_COUNT) & ~flush;
  assign push_fire  = push_valid & push_ready;
  assign empty      = (count == '0);
  assign fifo_count = count;
  assign can_pop    = run & ~empty;

  always_comb begin
    pop       = 1'b0;
    state_nxt = state;
    bub_nxt   = bub_cnt;
    if (flush) begin
      state_nxt = S_IDLE;
      bub_nxt   = 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (can_pop) begin
            pop       = 1'b1;
            state_nxt = S_ISSUE;
          end
        end
        S_ISSUE: begin
          // ISSUE is only entered through a pop, so the register holds the issued op.
          if (instruction_Register[12] && (BUBBLES > 0)) begin
            state_nxt = S_STALL;
            bub_nxt   = 3'(BUBBLES);
          end else if (can_pop) begin
            pop = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
        S_STALL: begin
          bub_nxt = bub_cnt - 3'd1;
          if (bub_cnt <= 3'd1) begin
            bub_nxt = 3'd0;
            if (can_pop) begin
              pop       = 1'b1;
              state_nxt = S_ISSUE;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_fire) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      state                <= S_IDLE;
      bub_cnt              <= 3'd0;
      instruction_Register <= NOP_WORD;
      issue_valid          <= 1'b0;
    end else begin
      state                <= state_nxt;
      bub_cnt              <= bub_nxt;
      instruction_Register <= pop ? mem[rd_ptr] : NOP_WORD;
      issue_valid          <= pop;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_fire) wr_ptr <= wr_ptr + AW'(1);
        if (pop)       rd_ptr <= rd_ptr + AW'(1);
        case ({push_fire, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

`ifdef SEQ_PERF_COUNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issued_count <= 32'd0;
      bubble_count <= 32'd0;
    end else if (flush) begin
      issued_count <= 32'd0;
      bubble_count <= 32'd0;
    end else begin
      if (issue_valid && issued_count != 32'hFFFF_FFFF)
        issued_count <= issued_count + 32'd1;
      if (state == S_STALL && bubble_count != 32'hFFFF_FFFF)
        bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb/tb_instruction_sequencer.sv - scoreboard bench for instruction_sequencer
// Optional SEQ_PERF_COUNT_EN section checks the performance counters.
module tb_instruction_sequencer;

  localparam int          DEPTH = 16;
  localparam int          BUB   = 2;
  localparam logic [12:0] NOP   = 13'h0800;

  logic        clock, reset, push_valid, push_ready, run, flush, issue_valid, empty;
  logic [12:0] push_data, instruction_Register;
  logic [4:0]  fifo_count;
`ifdef SEQ_PERF_COUNT_EN
  logic [31:0] issued_count, bubble_count;
`endif

  instruction_sequencer #(.DEPTH(DEPTH), .BUBBLES(BUB), .NOP_WORD(NOP)) dut (
    .clock(clock), .reset(reset), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .run(run), .flush(flush),
    .instruction_Register(instruction_Register), .issue_valid(issue_valid),
    .fifo_count(fifo_count), .empty(empty)
`ifdef SEQ_PERF_COUNT_EN
    , .issued_count(issued_count), .bubble_count(bubble_count)
`endif
  );

  typedef struct {
    logic [12:0] word;
    int          gap;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;
  int   last_issue = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [12:0] w, input int gap, input bit exp_it);
    push_valid = 1'b1;
    push_data  = w;
    if (exp_it) sb.push_back('{w, gap});
    cyc(1);
    push_valid = 1'b0;
  endtask

  // gap > 0 requires that many cycles since the previous issue
  always @(negedge clock) begin
    if (!reset) begin
      cyc_n++;
      if (issue_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_issue: got %h expected none", instruction_Register);
        end else begin
          e = sb.pop_front();
          chk("issue_word", 32'(instruction_Register), 32'(e.word));
          if (e.gap > 0) chk("issue_gap", 32'(cyc_n - last_issue), 32'(e.gap));
        end
        last_issue = cyc_n;
      end else begin
        chk("idle_nop", 32'(instruction_Register), 32'(NOP));
      end
    end
  end

  initial begin
    reset = 1'b1; push_valid = 1'b0; push_data = '0; run = 1'b0; flush = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ready", 32'(push_ready), 1);
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_instr", 32'(instruction_Register), 32'(NOP));

    // reset while words are queued and run is raised
    for (int i = 1; i <= 5; i++) push_word(13'(i), 0, 1'b0);
    chk("t1_count5", 32'(fifo_count), 5);
    reset = 1'b1; run = 1'b1;
    cyc(1);
    chk("t1_count", 32'(fifo_count), 0);
    chk("t1_instr", 32'(instruction_Register), 32'(NOP));
    chk("t1_valid", 32'(issue_valid), 0);
    chk("t1_empty", 32'(empty), 1);
    run = 1'b0; reset = 1'b0;
    cyc(1);

    // back-to-back non-ALU ops
    push_word(13'h0012, 0, 1'b1);
    push_word(13'h0034, 1, 1'b1);
    run = 1'b1;
    cyc(6);
    run = 1'b0;
    chk("t2_empty", 32'(empty), 1);

    // ALU op followed by BUB bubbles
    push_word(13'h1801, 0, 1'b1);
    push_word(13'h0005, BUB + 1, 1'b1);
    run = 1'b1;
    cyc(8);
    run = 1'b0;
    chk("t3_empty", 32'(empty), 1);

    // fill to full, overflow attempt, then drain
    for (int i = 0; i < DEPTH; i++) push_word(13'h0040 + 13'(i), (i == 0) ? 0 : 1, 1'b1);
    chk("t4_ready", 32'(push_ready), 0);
    chk("t4_count", 32'(fifo_count), DEPTH);
    push_word(13'h0ABC, 0, 1'b0);
    chk("t4_count_after_drop", 32'(fifo_count), DEPTH);
    run = 1'b1;
    cyc(DEPTH + 4);
    chk("t4_drained_empty", 32'(empty), 1);
    chk("t4_drained_count", 32'(fifo_count), 0);
    chk("t4_drained_valid", 32'(issue_valid), 0);
    chk("t4_drained_instr", 32'(instruction_Register), 32'(NOP));
    run = 1'b0;

    // flush while stalling with 7 words queued
    push_word(13'h1000, 0, 1'b1);
    for (int i = 1; i <= 7; i++) push_word(13'h0060 + 13'(i), 0, 1'b0);
    run = 1'b1;
    cyc(2);
    chk("t5_count7", 32'(fifo_count), 7);
    flush = 1'b1;
    #1;
    chk("t5_ready_flush", 32'(push_ready), 0);
    cyc(1);
    flush = 1'b0;
    chk("t5_count", 32'(fifo_count), 0);
    chk("t5_empty", 32'(empty), 1);
    chk("t5_valid", 32'(issue_valid), 0);
    chk("t5_instr", 32'(instruction_Register), 32'(NOP));
    cyc(1);
    chk("t5_valid_next", 32'(issue_valid), 0);
    push_word(13'h0077, 0, 1'b1);
    cyc(4);
    run = 1'b0;
    chk("t5_post_empty", 32'(empty), 1);

`ifdef SEQ_PERF_COUNT_EN
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
    chk("t6_issued_clr", issued_count, 0);
    chk("t6_bubble_clr", bubble_count, 0);
    push_word(13'h1001, 0, 1'b1);
    push_word(13'h1002, BUB + 1, 1'b1);
    push_word(13'h1003, BUB + 1, 1'b1);
    run = 1'b1;
    cyc(15);
    run = 1'b0;
    chk("t6_issued", issued_count, 3);
    chk("t6_bubble", bubble_count, 32'(3 * BUB));
`endif

    cyc(2);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
